// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter: default widths and the
// C-instruction jump-bit encodings {j1,j2,j3}.
package program_counter_pkg;

   localparam int WIDTH     = 16;
   localparam int CNT_WIDTH = 8;

   localparam logic [2:0] JNULL = 3'b000;
   localparam logic [2:0] JGT   = 3'b001;
   localparam logic [2:0] JEQ   = 3'b010;
   localparam logic [2:0] JGE   = 3'b011;
   localparam logic [2:0] JLT   = 3'b100;
   localparam logic [2:0] JNE   = 3'b101;
   localparam logic [2:0] JLE   = 3'b110;
   localparam logic [2:0] JMP   = 3'b111;

endpackage

// File: rtl/program_counter_jump_cond.sv
// Gate primitives plus the combinational jump-condition evaluator that turns
// the ALU flags and jump bits into a taken/not-taken decision.
module and_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module not_gate (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

module jump_cond (
   input  logic       is_c_instr,
   input  logic [2:0] j_bits,
   input  logic       zr,
   input  logic       ng,
   output logic       take
);
   import program_counter_pkg::*;

   logic not_zr, not_ng, pos;
   logic hit_ng, hit_zr, hit_pos;
   logic any_lo, any_hit;

   // A result is positive only when it is neither zero nor negative.
   not_gate u_not_zr (.a(zr), .y(not_zr));
   not_gate u_not_ng (.a(ng), .y(not_ng));
   and_gate u_pos    (.a(not_zr), .b(not_ng), .y(pos));

   and_gate u_hit_ng  (.a(j_bits[2]), .b(ng),  .y(hit_ng));
   and_gate u_hit_zr  (.a(j_bits[1]), .b(zr),  .y(hit_zr));
   and_gate u_hit_pos (.a(j_bits[0]), .b(pos), .y(hit_pos));

   or_gate  u_any_lo  (.a(hit_ng), .b(hit_zr),  .y(any_lo));
   or_gate  u_any_hit (.a(any_lo), .b(hit_pos), .y(any_hit));

   // A-instructions carry no jump field, so they never jump.
   and_gate u_take (.a(is_c_instr), .b(any_hit), .y(take));

endmodule

// File: rtl/program_counter.sv
// Program counter: registered instruction address with jump/increment/hold
// selection, a taken-jump flag and a saturating taken-jump counter.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int WIDTH     = program_counter_pkg::WIDTH,
   parameter int CNT_WIDTH = program_counter_pkg::CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 is_c_instr,
   input  logic [2:0]           j_bits,
   input  logic                 zr,
   input  logic                 ng,
   input  logic [WIDTH-1:0]     load_in,
   output logic [WIDTH-1:0]     pc_out,
   output logic                 jumped_out,
   output logic [CNT_WIDTH-1:0] jump_count
);

   logic                 take;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic                 jumped_q, jumped_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   jump_cond u_jump_cond (
      .is_c_instr (is_c_instr),
      .j_bits     (j_bits),
      .zr         (zr),
      .ng         (ng),
      .take       (take)
   );

   // Stalls hold every register; the decision inputs are only looked at
   // when en is high, so garbage on them during a stall cannot leak in.
   always_comb begin
      pc_d     = pc_q;
      jumped_d = jumped_q;
      count_d  = count_q;
      if (en) begin
         if (take) begin
            pc_d     = load_in;
            jumped_d = 1'b1;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
               count_d = count_q + CNT_WIDTH'(1);
            end
         end else begin
            pc_d     = pc_q + WIDTH'(1);
            jumped_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         jumped_q <= 1'b0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         jumped_q <= jumped_d;
         count_q  <= count_d;
      end
   end

   assign pc_out     = pc_q;
   assign jumped_out = jumped_q;
   assign jump_count = count_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter against a mnemonic-level model.
module tb_program_counter;
   import program_counter_pkg::*;

   logic        clk = 1'b0;
   logic        reset, en, is_c_instr, zr, ng;
   logic [2:0]  j_bits;
   logic [15:0] load_in;
   logic [15:0] pc_out;
   logic        jumped_out;
   logic [7:0]  jump_count;

   logic [15:0] m_pc;
   logic        m_jumped;
   logic [7:0]  m_cnt;
   int          compared = 0;
   int          mismatched = 0;

   program_counter dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .is_c_instr (is_c_instr),
      .j_bits     (j_bits),
      .zr         (zr),
      .ng         (ng),
      .load_in    (load_in),
      .pc_out     (pc_out),
      .jumped_out (jumped_out),
      .jump_count (jump_count)
   );

   always #5 clk = ~clk;

   // Jump decision stated per mnemonic in terms of the ALU result sign.
   function automatic bit expect_take(input logic c, input logic [2:0] j,
                                      input logic z, input logic n);
      bit p;
      p = !z && !n;
      if (!c) return 1'b0;
      case (j)
         JNULL:   return 1'b0;
         JGT:     return p;
         JEQ:     return z;
         JGE:     return z || p;
         JLT:     return n;
         JNE:     return !z;
         JLE:     return n || z;
         default: return 1'b1;
      endcase
   endfunction

   // Selects a legal flag pair: 0 = zero result, 1 = negative, 2 = positive.
   task automatic set_flags(input int kind);
      zr = (kind == 0);
      ng = (kind == 1);
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_pc = 16'h0; m_jumped = 1'b0; m_cnt = 8'h0;
      end else if (en) begin
         if (expect_take(is_c_instr, j_bits, zr, ng)) begin
            m_pc = load_in; m_jumped = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h1;
         end else begin
            m_pc = m_pc + 16'h1; m_jumped = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; is_c_instr = 1'b1; j_bits = JMP; set_flags(2);
      for (int i = 0; i < 3; i++) begin
         load_in = 16'($urandom);
         step();
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         compared++;
         if ({pc_out, jumped_out, jump_count} !== 25'h0) begin
            mismatched++;
            $display("[TB] FAIL reset: got pc=%h j=%b cnt=%h want all zero",
                     pc_out, jumped_out, jump_count);
         end
      end
   endtask

   task automatic test_increment();
      reset = 1'b0; en = 1'b1; is_c_instr = 1'b0; j_bits = JMP;
      for (int i = 1; i <= 5; i++) begin
         step();
         compared++;
         if (pc_out !== 16'(i) || jumped_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL increment: got pc=%h j=%b want pc=%h j=0",
                     pc_out, jumped_out, 16'(i));
         end
      end
   endtask

   task automatic test_jump();
      is_c_instr = 1'b1; j_bits = JEQ; set_flags(0); load_in = 16'h0040;
      step();
      compared++;
      if ({pc_out, jumped_out, jump_count} !== {16'h0040, 1'b1, 8'h01}) begin
         mismatched++;
         $display("[TB] FAIL jeq_taken: got pc=%h j=%b cnt=%h want 0040/1/01",
                  pc_out, jumped_out, jump_count);
      end
      is_c_instr = 1'b0;
      step();
      compared++;
      if (pc_out !== 16'h0041 || jumped_out !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL after_jump: got pc=%h j=%b want 0041/0", pc_out, jumped_out);
      end
   endtask

   task automatic test_sweep();
      is_c_instr = 1'b1; load_in = 16'h0100;
      for (int j = 0; j < 8; j++) begin
         for (int k = 0; k < 3; k++) begin
            j_bits = 3'(j); set_flags(k);
            step();
            compared++;
            if ({pc_out, jumped_out, jump_count} !== {m_pc, m_jumped, m_cnt}) begin
               mismatched++;
               $display("[TB] FAIL sweep j=%b kind=%0d: got pc=%h j=%b cnt=%h want pc=%h j=%b cnt=%h",
                        3'(j), k, pc_out, jumped_out, jump_count, m_pc, m_jumped, m_cnt);
            end
            if (j == 0 || j == 7) begin
               compared++;
               if (jumped_out !== (j == 7)) begin
                  mismatched++;
                  $display("[TB] FAIL sweep_edge j=%b: got jumped=%b want %b",
                           3'(j), jumped_out, (j == 7));
               end
            end
         end
      end
   endtask

   task automatic test_wrap_and_stall();
      logic [15:0] pc_hold;
      logic [7:0]  cnt_hold;
      is_c_instr = 1'b1; j_bits = JMP; load_in = 16'hFFFF;
      step();
      is_c_instr = 1'b0;
      step();
      compared++;
      if (pc_out !== 16'h0000 || jumped_out !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL wrap: got pc=%h j=%b want 0000/0", pc_out, jumped_out);
      end
      // Jump to own address, then stall with a taken jump presented.
      is_c_instr = 1'b1; load_in = 16'h0000;
      step();
      pc_hold = pc_out; cnt_hold = jump_count;
      compared++;
      if ({pc_out, jumped_out, jump_count} !== {m_pc, m_jumped, m_cnt}) begin
         mismatched++;
         $display("[TB] FAIL self_jump: got pc=%h j=%b cnt=%h want pc=%h j=%b cnt=%h",
                  pc_out, jumped_out, jump_count, m_pc, m_jumped, m_cnt);
      end
      en = 1'b0; load_in = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         step();
         compared++;
         if ({pc_out, jumped_out, jump_count} !== {pc_hold, 1'b1, cnt_hold}) begin
            mismatched++;
            $display("[TB] FAIL stall: got pc=%h j=%b cnt=%h want pc=%h j=1 cnt=%h",
                     pc_out, jumped_out, jump_count, pc_hold, cnt_hold);
         end
      end
      is_c_instr = 1'bx; j_bits = 3'bxxx; zr = 1'bx; ng = 1'bx; load_in = 'x;
      step();
      compared++;
      if ({pc_out, jumped_out, jump_count} !== {pc_hold, 1'b1, cnt_hold}) begin
         mismatched++;
         $display("[TB] FAIL stall_x: got pc=%h j=%b cnt=%h want pc=%h j=1 cnt=%h",
                  pc_out, jumped_out, jump_count, pc_hold, cnt_hold);
      end
      // Reset arriving mid-stall still clears everything.
      set_flags(2); is_c_instr = 1'b1; j_bits = JMP; load_in = 16'h0; reset = 1'b1;
      step();
      compared++;
      if ({pc_out, jumped_out, jump_count} !== 25'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_stall: got pc=%h j=%b cnt=%h want all zero",
                  pc_out, jumped_out, jump_count);
      end
      reset = 1'b0; en = 1'b1;
   endtask

   task automatic test_saturate();
      is_c_instr = 1'b1; j_bits = JMP;
      for (int i = 0; i < 300; i++) begin
         load_in = 16'($urandom);
         step();
         if (i == 254 || i == 299) begin
            compared++;
            if (jump_count !== 8'hFF || pc_out !== m_pc) begin
               mismatched++;
               $display("[TB] FAIL saturate i=%0d: got cnt=%h pc=%h want cnt=ff pc=%h",
                        i, jump_count, pc_out, m_pc);
            end
         end
      end
      reset = 1'b1;
      step();
      compared++;
      if ({pc_out, jumped_out, jump_count} !== 25'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_with_take: got pc=%h j=%b cnt=%h want all zero",
                  pc_out, jumped_out, jump_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         en         = ($urandom_range(0, 3) != 0);
         is_c_instr = 1'($urandom);
         j_bits     = 3'($urandom);
         set_flags(int'($urandom_range(0, 2)));
         load_in    = ($urandom_range(0, 7) == 0) ? m_pc : 16'($urandom);
         step();
         compared++;
         if ({pc_out, jumped_out, jump_count} !== {m_pc, m_jumped, m_cnt}) begin
            mismatched++;
            $display("[TB] FAIL random cyc=%0d: got pc=%h j=%b cnt=%h want pc=%h j=%b cnt=%h",
                     i, pc_out, jumped_out, jump_count, m_pc, m_jumped, m_cnt);
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; is_c_instr = 1'b0; j_bits = JNULL;
      zr = 1'b0; ng = 1'b0; load_in = 16'h0;
      m_pc = 16'h0; m_jumped = 1'b0; m_cnt = 8'h0;
      step();
      test_reset();
      test_increment();
      test_jump();
      test_sweep();
      test_wrap_and_stall();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
